// File: rtl/whirlpool_pkg.sv
// Shared types, widths and helpers for the whirlpool scan controller and core.
package whirlpool_pkg;

    localparam int unsigned WP_WIDTH  = 512;
    localparam int unsigned NONCE_W   = 32;
    localparam int unsigned TARGET_W  = 64;
    localparam int unsigned WP_ROUNDS = 10;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CHECK,
        REPORT
    } wp_state_e;

    typedef struct packed {
        logic [NONCE_W-1:0]  nonce;
        logic [TARGET_W-1:0] hash;
    } wp_hit_t;

    // Overwrite the nonce field of a block, leaving every other bit untouched.
    function automatic logic [WP_WIDTH-1:0] wp_insert_nonce(
        input logic [WP_WIDTH-1:0] blk,
        input logic [NONCE_W-1:0]  nonce,
        input int unsigned         lsb
    );
        logic [WP_WIDTH-1:0] mask;
        mask = WP_WIDTH'({NONCE_W{1'b1}}) << lsb;
        return (blk & ~mask) | (WP_WIDTH'(nonce) << lsb);
    endfunction

    // Round constants for rounds 1..10; index 0 and out-of-range return zero.
    function automatic logic [63:0] wp_round_const(input logic [3:0] r);
        logic [63:0] rc;
        case (r)
            4'd1:    rc = 64'h1823_c6e8_87b8_014f;
            4'd2:    rc = 64'h36a6_d2f5_796f_9152;
            4'd3:    rc = 64'h60bc_9b8e_a30c_7b35;
            4'd4:    rc = 64'h1de0_d7c2_2e4b_fe57;
            4'd5:    rc = 64'h1577_37e5_9ff0_4ada;
            4'd6:    rc = 64'h58c9_290a_b1a0_6b85;
            4'd7:    rc = 64'hbd5d_10f4_cb3e_0567;
            4'd8:    rc = 64'he427_418b_a77d_95d8;
            4'd9:    rc = 64'hfbee_7c66_dd17_479e;
            4'd10:   rc = 64'hca2d_bf07_ad5a_8333;
            default: rc = 64'h0;
        endcase
        return rc;
    endfunction

endpackage

// File: rtl/whirlpool_settle_timer.sv
// Loadable down-counter that times the multicycle settle window of the core.
module whirlpool_settle_timer #(
    parameter int unsigned CORE_LAT = 12
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic zero_c
);

    localparam int unsigned      CNT_W    = $clog2(CORE_LAT) + 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(CORE_LAT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero_c = (cnt == '0);

endmodule

// File: rtl/whirlpool_scan_ctrl.sv
// Nonce-range sequencer for the combinational whirlpool core; reports hash hits.
// Optional statistics counters are enabled with `define WP_SCAN_STATS_EN.
module whirlpool_scan_ctrl
    import whirlpool_pkg::*;
#(
    parameter int unsigned CORE_LAT  = 12,
    parameter int unsigned NONCE_LSB = 0,
    parameter int unsigned CMP_MSB   = 511
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                job_valid,
    output logic                job_ready,
    input  logic [WP_WIDTH-1:0] job_state,
    input  logic [WP_WIDTH-1:0] job_block,
    input  logic [NONCE_W-1:0]  job_nonce_start,
    input  logic [NONCE_W-1:0]  job_nonce_end,
    input  logic [TARGET_W-1:0] job_target,
    input  logic                abort,
    output logic [WP_WIDTH-1:0] core_block,
    output logic [WP_WIDTH-1:0] core_state,
    input  logic [WP_WIDTH-1:0] core_hash,
    output logic                hit_valid,
    input  logic                hit_ready,
    output logic [NONCE_W-1:0]  hit_nonce,
    output logic [TARGET_W-1:0] hit_hash,
    output logic                busy,
    output logic                done
`ifdef WP_SCAN_STATS_EN
    ,
    output logic [47:0]         stat_hashes,
    output logic [15:0]         stat_hits
`endif
);

    wp_state_e           state, state_nxt;
    logic [NONCE_W-1:0]  nonce_q, nonce_nxt;
    logic [NONCE_W-1:0]  end_q, end_nxt;
    logic [TARGET_W-1:0] target_q, target_nxt;
    logic [WP_WIDTH-1:0] block_nxt, cstate_nxt;
    wp_hit_t             hit_q, hit_nxt;
    logic                hit_valid_nxt, done_nxt, busy_nxt, job_ready_nxt;
    logic                timer_load, timer_zero_c, advance;
    logic                job_accept_c, is_hit_c, at_end_c;
    logic [TARGET_W-1:0] cmp_slice_c;
    logic                unused_hash_c;

    assign cmp_slice_c   = core_hash[CMP_MSB -: TARGET_W];
    assign is_hit_c      = (cmp_slice_c <= target_q);
    assign at_end_c      = (nonce_q == end_q);
    assign job_accept_c  = (state == IDLE) && job_valid;
    assign unused_hash_c = ^core_hash;

    whirlpool_settle_timer #(
        .CORE_LAT (CORE_LAT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (timer_load),
        .en     (state == SETTLE),
        .zero_c (timer_zero_c)
    );

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            nonce_q    <= '0;
            end_q      <= '0;
            target_q   <= '0;
            core_block <= '0;
            core_state <= '0;
            hit_q      <= '0;
            hit_valid  <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
            job_ready  <= 1'b1;
        end else begin
            state      <= state_nxt;
            nonce_q    <= nonce_nxt;
            end_q      <= end_nxt;
            target_q   <= target_nxt;
            core_block <= block_nxt;
            core_state <= cstate_nxt;
            hit_q      <= hit_nxt;
            hit_valid  <= hit_valid_nxt;
            done       <= done_nxt;
            busy       <= busy_nxt;
            job_ready  <= job_ready_nxt;
        end
    end

    // Next-state and next-output logic; abort wins over hits and handshakes.
    always_comb begin
        state_nxt     = state;
        nonce_nxt     = nonce_q;
        end_nxt       = end_q;
        target_nxt    = target_q;
        block_nxt     = core_block;
        cstate_nxt    = core_state;
        hit_nxt       = hit_q;
        hit_valid_nxt = hit_valid;
        done_nxt      = 1'b0;
        timer_load    = 1'b0;
        advance       = 1'b0;

        case (state)
            IDLE: begin
                if (job_valid) begin
                    nonce_nxt  = job_nonce_start;
                    end_nxt    = job_nonce_end;
                    target_nxt = job_target;
                    cstate_nxt = job_state;
                    block_nxt  = wp_insert_nonce(job_block, job_nonce_start, NONCE_LSB);
                    timer_load = 1'b1;
                    state_nxt  = SETTLE;
                end
            end
            SETTLE: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (timer_zero_c) begin
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (is_hit_c) begin
                    hit_nxt.nonce = nonce_q;
                    hit_nxt.hash  = cmp_slice_c;
                    hit_valid_nxt = 1'b1;
                    state_nxt     = REPORT;
                end else if (at_end_c) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    advance = 1'b1;
                end
            end
            REPORT: begin
                if (abort) begin
                    hit_valid_nxt = 1'b0;
                    state_nxt     = IDLE;
                end else if (hit_ready) begin
                    hit_valid_nxt = 1'b0;
                    if (at_end_c) begin
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: begin
                hit_valid_nxt = 1'b0;
                state_nxt     = IDLE;
            end
        endcase

        // Step to the next nonce; wraps modulo 2^32.
        if (advance) begin
            nonce_nxt  = nonce_q + NONCE_W'(1);
            block_nxt  = wp_insert_nonce(core_block, nonce_nxt, NONCE_LSB);
            timer_load = 1'b1;
            state_nxt  = SETTLE;
        end

        busy_nxt      = (state_nxt != IDLE);
        job_ready_nxt = (state_nxt == IDLE);
    end

    assign hit_nonce = hit_q.nonce;
    assign hit_hash  = hit_q.hash;

`ifdef WP_SCAN_STATS_EN
    // Saturating evaluation and hit counters, cleared on each new job.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_hashes <= '0;
            stat_hits   <= '0;
        end else if (job_accept_c) begin
            stat_hashes <= '0;
            stat_hits   <= '0;
        end else if (state == CHECK) begin
            if (stat_hashes != '1) begin
                stat_hashes <= stat_hashes + 48'd1;
            end
            if (!abort && is_hit_c && (stat_hits != '1)) begin
                stat_hits <= stat_hits + 16'd1;
            end
        end
    end
`endif

endmodule

// File: doc/whirlpool_scan_ctrl.md
Name: whirlpool_scan_ctrl

Overview:
Sequencer that drives the combinational 10-round whirlpool core through a nonce range for one mining job. It loads a job (midstate, block template, nonce range, target), inserts each nonce into the block, and waits a fixed multicycle settle time for the core. It then compares the hash against the target and reports hits through a valid/ready channel. It sits between the job-distribution logic and the whirlpool core instance.

Parameters:
CORE_LAT, 12, cycles allowed for core inputs to settle to a valid hash (multicycle constraint); must be >= 1
NONCE_LSB, 0, bit index of the 32-bit nonce field inside the 512-bit block
CMP_MSB, 511, MSB of the 64-bit hash slice compared against the target (slice = hash[CMP_MSB -: 64])

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-low reset
job_valid  in  1  job offered
job_ready  out  1  controller can accept a job
job_state  in  512  chaining state/midstate for the core
job_block  in  512  block template; nonce field overwritten
job_nonce_start  in  32  first nonce, inclusive
job_nonce_end  in  32  last nonce, inclusive
job_target  in  64  hit if hash slice <= target (unsigned)
abort  in  1  abandon current job
core_block  out  512  block presented to core
core_state  out  512  state presented to core
core_hash  in  512  core hash output
hit_valid  out  1  hit available
hit_ready  in  1  hit consumer ready
hit_nonce  out  32  nonce that produced the hit
hit_hash  out  64  compared hash slice of the hit
busy  out  1  high when not IDLE
done  out  1  one-cycle pulse on natural range completion

Behaviour:
- Reset (rst low, async): state IDLE; job_ready=1; hit_valid=0; done=0; busy=0; core_block, core_state, hit_nonce, hit_hash, nonce and target registers = 0.
- States: IDLE, SETTLE, CHECK, REPORT.
- IDLE: job_ready=1. On job_valid, latch all job fields: nonce<=start, core_state<=job_state, core_block<=job_block with the nonce field replaced by start. Load settle counter with CORE_LAT-1 and go to SETTLE. abort is ignored in IDLE.
- SETTLE: decrement the counter each cycle. At counter==0, go to CHECK. Occupies exactly CORE_LAT cycles.
- CHECK: evaluate hit = core_hash[CMP_MSB -: 64] <= target.
  - On hit: register hit_nonce and hit_hash, then go to REPORT.
  - No hit and nonce==end: pulse done and go to IDLE.
  - Otherwise: nonce<=nonce+1 (mod 2^32), update the core_block nonce field in the same cycle, reload the counter, and go to SETTLE.
- REPORT: hit_valid=1. hit_nonce and hit_hash are held stable until hit_ready. On the hit_valid&hit_ready cycle, hit_valid drops next cycle. The controller then follows the same end/advance rules as a non-hit CHECK: done pulse if nonce==end, else advance and SETTLE.
- Throughput: CORE_LAT+1 cycles per nonce without hits. Each hit adds at least 1 cycle of REPORT.
- Wrap-around: nonce increments modulo 2^32. If end<start, the range wraps through FFFFFFFF to 0. If start==end, exactly one nonce is evaluated. The full 2^32 range is start=end+1.
- abort in SETTLE/CHECK/REPORT: next state IDLE, hit_valid=0 (a pending hit is dropped), no done pulse. abort takes priority over every other event in the same cycle, including a hit_valid&hit_ready handshake (that hit counts as consumed).
- Reset mid-job returns to reset values immediately; no done pulse.
- core_block/core_state change only on job accept and nonce advance, never during SETTLE.

Optional Feature:
WP_SCAN_STATS_EN.
- Defined: adds output stat_hashes[47:0], which increments on every CHECK cycle (nonces evaluated), and output stat_hits[15:0], which increments on every hit entering REPORT.
  - Both counters saturate at all-ones.
  - Both clear on reset and on job accept.
- Undefined: neither port nor counter exists.

Decomposition:
- Shared package whirlpool_pkg:
  - state enum type (IDLE/SETTLE/CHECK/REPORT);
  - WP_WIDTH=512, NONCE_W=32, TARGET_W=64;
  - function inserting a nonce into a block at NONCE_LSB.
- The round-constant table belongs in the same package for reuse by the core.
- One natural sub-module: whirlpool_settle_timer (loadable down-counter with zero flag, width $clog2(CORE_LAT)+1).

Test Plan:
- CORE_LAT=3, start=10, end=12, target=0, core model with hash never <= target → three nonces evaluated at 4-cycle spacing, core_block nonce field = 10, 11, 12, done pulses once, no hit_valid.
- start=5, end=5, target=FFFFFFFFFFFFFFFF → one hit with hit_nonce=5. Hold hit_ready low 7 cycles → hit_valid and data stable. Release → done pulses the cycle after the handshake.
- start=FFFFFFFE, end=00000001 → nonces FFFFFFFE, FFFFFFFF, 0, 1 evaluated in order, then done.
- Model hit only at nonce 0x20 in range 0x1E..0x22 → one hit (nonce 0x20, hit_hash = model slice). Scan resumes at 0x21, then done.
- abort asserted in SETTLE of the second nonce, and separately in REPORT with hit_ready=1 → IDLE next cycle, job_ready=1, hit_valid=0, no done. A new job is accepted the following cycle.
- rst pulsed low mid-SETTLE, asynchronously between clock edges → outputs take reset values immediately. With WP_SCAN_STATS_EN: stat_hashes=0, and it counts 3 after a 3-nonce job.
